spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Receive-side companion to the perceptron neuron. It consumes the neuron's single-bit spike output (`v_out`) and decodes the spike train back into numbers. It counts rising edges over a programmable window of clock cycles and reports the spike rate. Optionally it also measures the inter-spike interval (ISI). It sits beside the neuron in the tile top, and its results drive `uo_out`/`uio_out` for observation and readout.

## Interface
- `WINDOW_W`, 8: width of `window_len` (window length up to 2^WINDOW_W-1 cycles)
- `CNT_W`, 8: width of `rate_out`; the spike count saturates at 2^CNT_W-1
- `ISI_W`, 8: width of `isi_out`; the interval counter saturates at 2^ISI_W-1
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  1 = decode; 0 = idle, with all internal counters cleared
- `spike_in`  in  1  spike train, synchronous to `clk` (neuron `v_out`)
- `window_len`  in  WINDOW_W  window length N in cycles; 0 is treated as 1
- `rate_out`  out  CNT_W  spike count of the last completed window
- `rate_valid`  out  1  one-cycle pulse when `rate_out` updates
- `overflow`  out  1  last completed window saturated the count
- `isi_out`  out  ISI_W  cycles between the last two spike edges
- `isi_valid`  out  1  one-cycle pulse when `isi_out` updates

## Operation
- Edge detect:
  - `spike_prev` registers `spike_in` every cycle in all states.
  - edge = `spike_in & ~spike_prev`.
  - A level held high counts exactly once.
  - A level already high when `enable` rises does not count.
- States:
  - IDLE: entered when `enable`=0.
    - Window counter, spike counter, ISI counter and `isi_seen` are cleared.
    - `rate_out`, `overflow` and `isi_out` hold their last values.
  - IDLE -> COUNT on `enable`=1.
    - N is latched from `window_len` on this transition.
  - COUNT: window index w runs 0..N-1 and increments each cycle; the spike counter adds 1 per edge.
  - At w = N-1:
    - `rate_out` is loaded with the count, including an edge in cycle N-1.
    - `overflow` is loaded with the saturation flag.
    - `rate_valid` is pulsed.
    - The spike counter is cleared, w returns to 0, and N is re-latched from `window_len`.
    - Windows run back to back with no gap cycle.
  - COUNT -> IDLE when `enable`=0 at any w.
    - The partial window is discarded; no `rate_valid` pulse.
- Saturation: the spike counter stops at 2^CNT_W-1, and an internal sat flag is set. The flag clears at each window boundary.
- Changes to `window_len` mid-window take effect only at the next window boundary.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - `rate_out`, `isi_out`, `rate_valid`, `isi_valid`, `overflow` = 0.
  - All counters and `spike_prev` = 0.
- Latency: an edge in cycle t of the final window cycle appears in `rate_out` from cycle t+1, with `rate_valid`=1 during cycle t+1 only.
- First window: spans the N cycles after the IDLE->COUNT clock edge.
- Minimum ISI is 2, because an edge requires a preceding 0.
- `reset` asserted mid-window aborts the window. After release, counting starts from IDLE.

## Configuration
- `SPIKE_ISI_EN` defined:
  - The ISI counter increments every COUNT cycle, saturating at 2^ISI_W-1.
  - On an edge with `isi_seen`=1: `isi_out` <= counter value, `isi_valid` pulses the next cycle, and the counter restarts at 1.
  - On the first edge after enable: `isi_seen` is set and the counter restarts at 1, with no pulse.
- `SPIKE_ISI_EN` undefined:
  - The ISI logic is removed.
  - `isi_out` and `isi_valid` are tied to 0.

## Test plan
- `window_len`=10; 1-cycle spikes at w=0,4,8 of every window -> `rate_out`=3 and `rate_valid` pulse once per 10 cycles; `overflow`=0.
- `spike_in` held high for 25 cycles starting at w=2, `window_len`=10 -> window 1 reports 1, windows 2 and 3 report 0.
- `CNT_W`=4, `window_len`=40, `spike_in` toggling every cycle -> 20 edges; `rate_out`=15, `overflow`=1. The next window with no spikes reports 0 with `overflow`=0.
- `SPIKE_ISI_EN` defined; edges at cycles 5, 17 and 20 after enable -> no pulse at cycle 5; `isi_out`=12 then 3, each with one `isi_valid` pulse.
- `reset` pulsed at w=6 with 2 edges counted, then released -> all outputs read 0 immediately. The next full window reports only post-reset edges.
- `enable` dropped at w=7, then re-raised -> no `rate_valid` for the aborted window; `rate_out` keeps the previous value until the next window completes.

Source files
------------

// File: rtl/spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_rate_decoder
// Brief    : Counts spike rising edges over a programmable window and reports
//            the rate. Optional inter-spike interval measurement is built when
//            the macro SPIKE_ISI_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spike_rate_decoder #(
    parameter int WINDOW_W = 8,
    parameter int CNT_W    = 8,
    parameter int ISI_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                spike_in,
    input  logic [WINDOW_W-1:0] window_len,
    output logic [CNT_W-1:0]    rate_out,
    output logic                rate_valid,
    output logic                overflow,
    output logic [ISI_W-1:0]    isi_out,
    output logic                isi_valid
);

    localparam logic [0:0]       S_IDLE  = 1'b0;
    localparam logic [0:0]       S_COUNT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]          state;
    logic                spike_prev;
    logic [WINDOW_W-1:0] win_idx;
    logic [WINDOW_W-1:0] win_len;
    logic [CNT_W-1:0]    spike_cnt;
    logic                sat;

    logic                spike_edge;
    logic                cnt_full;
    logic                last_cycle;
    logic [CNT_W-1:0]    cnt_next;
    logic                sat_next;
    logic [WINDOW_W-1:0] len_eff;

    assign spike_edge = spike_in & ~spike_prev;
    assign cnt_full   = (spike_cnt == CNT_MAX);
    assign cnt_next   = (spike_edge && !cnt_full) ? spike_cnt + CNT_W'(1) : spike_cnt;
    // sat marks an edge that arrived while the count was already pinned
    assign sat_next   = sat | (spike_edge & cnt_full);
    assign last_cycle = (win_idx == win_len - WINDOW_W'(1));
    assign len_eff    = (window_len == '0) ? WINDOW_W'(1) : window_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spike_prev <= 1'b0;
        end else begin
            spike_prev <= spike_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            win_idx    <= '0;
            win_len    <= WINDOW_W'(1);
            spike_cnt  <= '0;
            sat        <= 1'b0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    win_idx   <= '0;
                    spike_cnt <= '0;
                    sat       <= 1'b0;
                    if (enable) begin
                        state   <= S_COUNT;
                        win_len <= len_eff;
                    end
                end
                S_COUNT: begin
                    if (!enable) begin
                        // partial window is dropped without a report
                        state     <= S_IDLE;
                        win_idx   <= '0;
                        spike_cnt <= '0;
                        sat       <= 1'b0;
                    end else if (last_cycle) begin
                        rate_out   <= cnt_next;
                        overflow   <= sat_next;
                        rate_valid <= 1'b1;
                        spike_cnt  <= '0;
                        sat        <= 1'b0;
                        win_idx    <= '0;
                        win_len    <= len_eff;
                    end else begin
                        win_idx   <= win_idx + WINDOW_W'(1);
                        spike_cnt <= cnt_next;
                        sat       <= sat_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SPIKE_ISI_EN
    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    logic [ISI_W-1:0] isi_cnt;
    logic             isi_seen;

    // interval counter free-runs across window boundaries while decoding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            isi_cnt   <= '0;
            isi_seen  <= 1'b0;
            isi_out   <= '0;
            isi_valid <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (state == S_COUNT && enable) begin
                if (spike_edge) begin
                    isi_cnt  <= ISI_W'(1);
                    isi_seen <= 1'b1;
                    if (isi_seen) begin
                        isi_out   <= isi_cnt;
                        isi_valid <= 1'b1;
                    end
                end else if (isi_cnt != ISI_MAX) begin
                    isi_cnt <= isi_cnt + ISI_W'(1);
                end
            end else begin
                isi_cnt  <= '0;
                isi_seen <= 1'b0;
            end
        end
    end
`else
    assign isi_out   = '0;
    assign isi_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spike_rate_decoder
// Brief    : Self-checking scoreboard bench for spike_rate_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_rate_decoder;

    localparam int WINDOW_W = 8;
    localparam int CNT_W    = 4;
    localparam int ISI_W    = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                spike_in;
    logic [WINDOW_W-1:0] window_len;
    logic [CNT_W-1:0]    rate_out;
    logic                rate_valid;
    logic                overflow;
    logic [ISI_W-1:0]    isi_out;
    logic                isi_valid;

    int errors = 0;
    int checks = 0;
    // entries encode {overflow, rate} as (ovf << CNT_W) | rate
    int rate_q[$];
    int isi_q[$];

    always #5 clk = ~clk;

    spike_rate_decoder #(
        .WINDOW_W(WINDOW_W),
        .CNT_W   (CNT_W),
        .ISI_W   (ISI_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .spike_in  (spike_in),
        .window_len(window_len),
        .rate_out  (rate_out),
        .rate_valid(rate_valid),
        .overflow  (overflow),
        .isi_out   (isi_out),
        .isi_valid (isi_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        enable   = 1'b0;
        spike_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [CNT_W+ISI_W+2:0] got;
        reset = 1'b1; enable = 1'b0; spike_in = 1'b0; window_len = 8'd10;
        repeat (3) tick();
        got = {rate_out, rate_valid, overflow, isi_out, isi_valid};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", got);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_steady_rate();
        logic [CNT_W:0] got;
        int exp;
        go_idle();
        window_len = 8'd10; enable = 1'b1; tick();
        for (int k = 0; k < 3; k++) begin
            rate_q.push_back(3);
            for (int w = 0; w < 10; w++) begin
                spike_in = (w == 0 || w == 4 || w == 8);
                tick();
                checks++;
                if (rate_valid !== (w == 9)) begin
                    errors++;
                    $display("FAIL steady_valid win=%0d w=%0d got=%b exp=%b", k, w, rate_valid, (w == 9));
                end
                if (rate_valid && rate_q.size() > 0) begin
                    exp = rate_q.pop_front();
                    got = {overflow, rate_out};
                    checks++;
                    if (got !== (CNT_W+1)'(exp)) begin
                        errors++;
                        $display("FAIL steady_rate win=%0d got=%0d exp=%0d", k, got, exp);
                    end
                end
            end
        end
        checks++;
        if (rate_q.size() != 0) begin
            errors++;
            $display("FAIL steady_missing got=%0d exp=0 pending", rate_q.size());
        end
        rate_q.delete();
    endtask

    task automatic test_held_level();
        logic [CNT_W:0] got;
        int exp;
        go_idle();
        window_len = 8'd10; enable = 1'b1; tick();
        rate_q.push_back(1); rate_q.push_back(0); rate_q.push_back(0);
        for (int c = 0; c < 30; c++) begin
            spike_in = (c >= 2 && c < 27);
            tick();
            checks++;
            if (rate_valid !== (c % 10 == 9)) begin
                errors++;
                $display("FAIL held_valid c=%0d got=%b exp=%b", c, rate_valid, (c % 10 == 9));
            end
            if (rate_valid && rate_q.size() > 0) begin
                exp = rate_q.pop_front();
                got = {overflow, rate_out};
                checks++;
                if (got !== (CNT_W+1)'(exp)) begin
                    errors++;
                    $display("FAIL held_rate c=%0d got=%0d exp=%0d", c, got, exp);
                end
            end
        end
        rate_q.delete();
    endtask

    task automatic test_saturation();
        logic [CNT_W:0] got;
        int exp;
        go_idle();
        window_len = 8'd40; enable = 1'b1; tick();
        rate_q.push_back((1 << CNT_W) | 15);
        rate_q.push_back(0);
        for (int c = 0; c < 80; c++) begin
            spike_in = (c < 40) && (c % 2 == 0);
            tick();
            checks++;
            if (rate_valid !== (c == 39 || c == 79)) begin
                errors++;
                $display("FAIL sat_valid c=%0d got=%b exp=%b", c, rate_valid, (c == 39 || c == 79));
            end
            if (rate_valid && rate_q.size() > 0) begin
                exp = rate_q.pop_front();
                got = {overflow, rate_out};
                checks++;
                if (got !== (CNT_W+1)'(exp)) begin
                    errors++;
                    $display("FAIL sat_rate c=%0d got=%0d exp=%0d", c, got, exp);
                end
            end
        end
        rate_q.delete();
    endtask

    task automatic test_zero_window();
        int exp;
        go_idle();
        window_len = 8'd0; enable = 1'b1; tick();
        for (int c = 0; c < 6; c++) begin
            spike_in = (c % 2 == 0);
            rate_q.push_back((c % 2 == 0) ? 1 : 0);
            tick();
            exp = rate_q.pop_front();
            checks++;
            if (rate_valid !== 1'b1 || rate_out !== CNT_W'(exp)) begin
                errors++;
                $display("FAIL zero_window c=%0d got=%b/%0d exp=1/%0d", c, rate_valid, rate_out, exp);
            end
        end
        rate_q.delete();
    endtask

    task automatic test_window_change();
        int exp;
        go_idle();
        window_len = 8'd6; enable = 1'b1; tick();
        rate_q.push_back(1); rate_q.push_back(1); rate_q.push_back(1);
        for (int c = 0; c < 12; c++) begin
            spike_in = (c == 1 || c == 7 || c == 10);
            if (c == 2) window_len = 8'd3;
            tick();
            checks++;
            if (rate_valid !== (c == 5 || c == 8 || c == 11)) begin
                errors++;
                $display("FAIL wchange_valid c=%0d got=%b exp=%b", c, rate_valid, (c == 5 || c == 8 || c == 11));
            end
            if (rate_valid && rate_q.size() > 0) begin
                exp = rate_q.pop_front();
                checks++;
                if (rate_out !== CNT_W'(exp)) begin
                    errors++;
                    $display("FAIL wchange_rate c=%0d got=%0d exp=%0d", c, rate_out, exp);
                end
            end
        end
        rate_q.delete();
    endtask

    task automatic test_isi();
        int exp;
        go_idle();
        window_len = 8'd40; enable = 1'b1; tick();
`ifdef SPIKE_ISI_EN
        isi_q.push_back(12); isi_q.push_back(3);
`endif
        for (int c = 0; c < 40; c++) begin
            spike_in = (c == 5 || c == 17 || c == 20);
            tick();
`ifdef SPIKE_ISI_EN
            checks++;
            if (isi_valid !== (c == 17 || c == 20)) begin
                errors++;
                $display("FAIL isi_valid c=%0d got=%b exp=%b", c, isi_valid, (c == 17 || c == 20));
            end
            if (isi_valid && isi_q.size() > 0) begin
                exp = isi_q.pop_front();
                checks++;
                if (isi_out !== ISI_W'(exp)) begin
                    errors++;
                    $display("FAIL isi_value c=%0d got=%0d exp=%0d", c, isi_out, exp);
                end
            end
`else
            checks++;
            if (isi_valid !== 1'b0 || isi_out !== '0) begin
                errors++;
                $display("FAIL isi_tied c=%0d got=%b/%0d exp=0/0", c, isi_valid, isi_out);
            end
`endif
        end
        checks++;
        if (rate_out !== CNT_W'(3)) begin
            errors++;
            $display("FAIL isi_rate got=%0d exp=3", rate_out);
        end
        isi_q.delete();
    endtask

    task automatic test_mid_reset();
        logic [CNT_W+ISI_W+2:0] got;
        int exp;
        go_idle();
        window_len = 8'd10; enable = 1'b1; tick();
        for (int w = 0; w < 6; w++) begin
            spike_in = (w == 1 || w == 4);
            tick();
        end
        spike_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        got = {rate_out, rate_valid, overflow, isi_out, isi_valid};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%h exp=0", got);
        end
        tick();
        reset = 1'b0;
        tick();
        rate_q.push_back(2);
        for (int w = 0; w < 10; w++) begin
            spike_in = (w == 2 || w == 5);
            tick();
            if (w == 9) begin
                exp = rate_q.pop_front();
                checks++;
                if (rate_valid !== 1'b1 || rate_out !== CNT_W'(exp)) begin
                    errors++;
                    $display("FAIL post_reset_rate got=%b/%0d exp=1/%0d", rate_valid, rate_out, exp);
                end
            end
        end
        rate_q.delete();
    endtask

    task automatic test_enable_drop();
        int exp;
        go_idle();
        window_len = 8'd10; enable = 1'b1; tick();
        rate_q.push_back(2);
        for (int w = 0; w < 10; w++) begin
            spike_in = (w == 0 || w == 4);
            tick();
        end
        exp = rate_q.pop_front();
        checks++;
        if (rate_valid !== 1'b1 || rate_out !== CNT_W'(exp)) begin
            errors++;
            $display("FAIL drop_first_rate got=%b/%0d exp=1/%0d", rate_valid, rate_out, exp);
        end
        for (int w = 0; w < 11; w++) begin
            spike_in = (w == 1 || w == 3 || w == 5);
            if (w >= 7) enable = 1'b0;
            tick();
            checks++;
            if (rate_valid !== 1'b0 || rate_out !== CNT_W'(2)) begin
                errors++;
                $display("FAIL drop_aborted w=%0d got=%b/%0d exp=0/2", w, rate_valid, rate_out);
            end
        end
        enable = 1'b1; tick();
        rate_q.push_back(1);
        for (int w = 0; w < 10; w++) begin
            spike_in = (w == 0);
            tick();
            if (w < 9) begin
                checks++;
                if (rate_valid !== 1'b0 || rate_out !== CNT_W'(2)) begin
                    errors++;
                    $display("FAIL drop_hold w=%0d got=%b/%0d exp=0/2", w, rate_valid, rate_out);
                end
            end else begin
                exp = rate_q.pop_front();
                checks++;
                if (rate_valid !== 1'b1 || rate_out !== CNT_W'(exp)) begin
                    errors++;
                    $display("FAIL drop_resume got=%b/%0d exp=1/%0d", rate_valid, rate_out, exp);
                end
            end
        end
        rate_q.delete();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; spike_in = 1'b0; window_len = '0;
        test_reset();
        test_steady_rate();
        test_held_level();
        test_saturation();
        test_zero_window();
        test_window_change();
        test_isi();
        test_mid_reset();
        test_enable_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
